md_scheduler: RTL and testbench

//  Sequences the shared HI/LO multiply/divide resource for the 5-stage MIPS pipeline.
//  - Accepts a MD-class op from stage E and models the multi-cycle latency of mult and div.
//  - Commits results to HI/LO.
//  - Produces the stage-D stall for any MD-class instruction (MD flag from the D controller) that arrives while the unit is busy.
//  - Suppresses ops that are flushed by an exception or interrupt detected in stage M.

---
 rtl/md_scheduler_pkg.sv | 29 ++
 rtl/md_alu.sv | 50 +++++
 rtl/md_scheduler.sv | 112 +++++++++++
 tb/tb_md_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/md_scheduler_pkg.sv
// Shared encodings for the HI/LO multiply/divide scheduler: MDOp codes and FSM states.
package md_scheduler_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_NONE  = 3'd6,
        MD_NONE2 = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } md_state_e;

    function automatic logic op_is_mul(input logic [2:0] op);
        return op[2:1] == 2'b00;
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/md_alu.sv
// Combinational product/quotient/remainder for the MD unit; the scheduler registers these at start.
module md_alu
    import md_scheduler_pkg::*;
(
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] Hi64,
    output logic [31:0] Lo64,
    output logic        DivZero
);

    logic        is_signed;
    logic [63:0] prod;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        is_signed = ~MDOp[0];
        prod      = {{32{is_signed & A[31]}}, A} * {{32{is_signed & B[31]}}, B};

        // Signed divide runs on magnitudes so 0x80000000 / -1 wraps cleanly instead of overflowing.
        mag_a = (is_signed && A[31]) ? (32'd0 - A) : A;
        mag_b = (is_signed && B[31]) ? (32'd0 - B) : B;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        uq   = mag_a / mag_b;
        ur   = mag_a % mag_b;
        quot = (is_signed && (A[31] ^ B[31])) ? (32'd0 - uq) : uq;
        rem  = (is_signed && A[31]) ? (32'd0 - ur) : ur;

        Hi64    = 32'd0;
        Lo64    = 32'd0;
        DivZero = 1'b0;
        if (op_is_mul(MDOp)) begin
            Hi64 = prod[63:32];
            Lo64 = prod[31:0];
        end else if (op_is_div(MDOp)) begin
            Hi64    = rem;
            Lo64    = quot;
            DivZero = (B == 32'd0);
        end
    end

endmodule

// File: rtl/md_scheduler.sv
// Sequences the shared HI/LO mult/div resource: models latency, commits HI/LO, raises the D-stage stall.
module md_scheduler
    import md_scheduler_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    input  logic        MDD,
    output logic        Busy,
    output logic        StallD,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output md_state_e   dbg_state
);

    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] DIV_LAST = 4'(DIV_CYCLES - 1);

    md_state_e   state;
    md_state_e   state_nx;
    logic [3:0]  cnt;
    logic [31:0] phi;
    logic [31:0] plo;
    logic        pdz;
    logic        go;
    logic        done;
    logic [31:0] alu_hi;
    logic [31:0] alu_lo;
    logic        alu_dz;

    md_alu u_alu (
        .MDOp    (MDOp),
        .A       (A),
        .B       (B),
        .Hi64    (alu_hi),
        .Lo64    (alu_lo),
        .DivZero (alu_dz)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Start is only honoured in IDLE; an op already in flight ignores Cancel and Start.
    always_comb begin
        state_nx = state;
        go       = Start & ~Cancel & (state == S_IDLE);
        done     = 1'b0;
        case (state)
            S_IDLE: begin
                if (go && op_is_mul(MDOp)) begin
                    state_nx = S_MUL;
                end else if (go && op_is_div(MDOp)) begin
                    state_nx = S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == 4'd0) begin
                    done     = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt <= 4'd0;
            phi <= 32'd0;
            plo <= 32'd0;
            pdz <= 1'b0;
            HI  <= 32'd0;
            LO  <= 32'd0;
        end else begin
            if (go && (op_is_mul(MDOp) || op_is_div(MDOp))) begin
                cnt <= op_is_mul(MDOp) ? MUL_LAST : DIV_LAST;
                phi <= alu_hi;
                plo <= alu_lo;
                pdz <= alu_dz;
            end else if (state != S_IDLE && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end

            // A divide by zero still burns its full latency but leaves HI/LO alone.
            if (done && !pdz) begin
                HI <= phi;
                LO <= plo;
            end else if (go && MDOp == MD_MTHI) begin
                HI <= A;
            end else if (go && MDOp == MD_MTLO) begin
                LO <= A;
            end
        end
    end

    assign Busy      = (state != S_IDLE);
    assign StallD    = MDD & (Busy | (Start & ~MDOp[2]));
    assign dbg_state = state;

endmodule

// File: tb/tb_md_scheduler.sv
// Directed bench for md_scheduler: latency, HI/LO commit values, stall, cancel and reset behaviour.
module tb_md_scheduler;
    import md_scheduler_pkg::*;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic [2:0]  MDOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        Cancel;
    logic        MDD;
    logic        Busy;
    logic        StallD;
    logic [31:0] HI;
    logic [31:0] LO;
    md_state_e   dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    md_scheduler #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .MDOp      (MDOp),
        .A         (A),
        .B         (B),
        .Cancel    (Cancel),
        .MDD       (MDD),
        .Busy      (Busy),
        .StallD    (StallD),
        .HI        (HI),
        .LO        (LO),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        MDOp  = op;
        A     = a;
        B     = b;
        tick();
        Start = 1'b0;
        MDOp  = MD_NONE;
        A     = 32'hFFFF_FFFF;
        B     = 32'hFFFF_FFFF;
    endtask

    task automatic wait_busy(input string tag, input int n, input logic exp_stall);
        for (int i = 0; i < n; i++) begin
            #1;
            check({tag, "_busy"}, 32'(Busy), 32'd1);
            check({tag, "_stall"}, 32'(StallD), 32'(exp_stall));
            tick();
        end
    endtask

    // scoreboard: expected {HI, LO} pairs queued at launch, popped at commit
    task automatic check_commit(input string tag);
        logic [31:0] eh;
        logic [31:0] el;
        #1;
        check({tag, "_idle"}, 32'(Busy), 32'd0);
        if (exp_q.size() < 2) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_queue: got %0d entries expected 2", tag, exp_q.size());
        end else begin
            eh = exp_q.pop_front();
            el = exp_q.pop_front();
            check({tag, "_hi"}, HI, eh);
            check({tag, "_lo"}, LO, el);
        end
    endtask

    initial begin
        Reset  = 1'b1;
        Start  = 1'b0;
        MDOp   = MD_NONE;
        A      = 32'd0;
        B      = 32'd0;
        Cancel = 1'b0;
        MDD    = 1'b0;
        #12;
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_stall", 32'(StallD), 32'd0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(S_IDLE));
        Reset = 1'b0;
        tick();

        // signed mult, operands scrambled after launch
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFA);
        Start = 1'b1; MDOp = MD_MULT; A = 32'hFFFF_FFFE; B = 32'd3;
        #1;
        check("mult_stall0", 32'(StallD), 32'd0);
        tick();
        Start = 1'b0; A = 32'h1234_5678; B = 32'h9ABC_DEF0;
        wait_busy("mult", 5, 1'b0);
        check_commit("mult");

        exp_q.push_back(32'h0000_0002);
        exp_q.push_back(32'hFFFF_FFFA);
        launch(MD_MULTU, 32'hFFFF_FFFE, 32'd3);
        wait_busy("multu", 5, 1'b0);
        check_commit("multu");

        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFD);
        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_busy("div", 10, 1'b0);
        check_commit("div");

        // divide by zero leaves the previous result in place
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFD);
        launch(MD_DIVU, 32'd7, 32'd0);
        wait_busy("divu0", 10, 1'b0);
        check_commit("divu0");

        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h8000_0000);
        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_busy("divovf", 10, 1'b0);
        check_commit("divovf");

        // MD op in D while a mult enters E
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0006);
        MDD = 1'b1;
        Start = 1'b1; MDOp = MD_MULT; A = 32'd2; B = 32'd3;
        #1;
        check("b2b_stall0", 32'(StallD), 32'd1);
        tick();
        Start = 1'b0; MDOp = MD_NONE;
        wait_busy("b2b", 5, 1'b1);
        #1;
        check("b2b_stall_drop", 32'(StallD), 32'd0);
        check_commit("b2b");
        MDD = 1'b0;

        // cancelled starts
        Start = 1'b1; MDOp = MD_MTHI; A = 32'h0000_1234; Cancel = 1'b1;
        tick();
        Start = 1'b1; MDOp = MD_MULT; A = 32'd5; B = 32'd5;
        #1;
        check("cancel_mthi_hi", HI, 32'd0);
        check("cancel_mthi_busy", 32'(Busy), 32'd0);
        tick();
        Start = 1'b0; Cancel = 1'b0;
        #1;
        check("cancel_mult_busy", 32'(Busy), 32'd0);
        check("cancel_mult_lo", LO, 32'd6);

        // Start while busy is ignored; Cancel during MUL does not kill the commit
        exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_003F);
        launch(MD_MULT, 32'd7, 32'd9);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin Start = 1'b1; MDOp = MD_MTHI; A = 32'h0000_AAAA; end
            if (i == 2) begin Start = 1'b0; MDOp = MD_NONE; Cancel = 1'b1; end
            if (i == 3) Cancel = 1'b0;
            #1;
            check("inflight_busy", 32'(Busy), 32'd1);
            tick();
        end
        check_commit("inflight");

        // mthi/mtlo back to back
        Start = 1'b1; MDOp = MD_MTHI; A = 32'hDEAD_BEEF;
        tick();
        MDOp = MD_MTLO; A = 32'd5;
        #1;
        check("mthi_busy", 32'(Busy), 32'd0);
        check("mthi_hi", HI, 32'hDEAD_BEEF);
        tick();
        Start = 1'b0; MDOp = MD_NONE;
        #1;
        check("mtlo_busy", 32'(Busy), 32'd0);
        check("mtlo_hi", HI, 32'hDEAD_BEEF);
        check("mtlo_lo", LO, 32'd5);

        // asynchronous reset in the fourth busy cycle of a divide
        launch(MD_DIV, 32'd100, 32'd7);
        tick();
        tick();
        tick();
        #1;
        check("pre_rst_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        check("async_rst_busy", 32'(Busy), 32'd0);
        check("async_rst_hi", HI, 32'd0);
        check("async_rst_lo", LO, 32'd0);
        Reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
        end
        #1;
        check("post_rst_busy", 32'(Busy), 32'd0);
        check("post_rst_hi", HI, 32'd0);
        check("post_rst_lo", LO, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
